// File: rtl/uart_config_rx_pkg.sv
// Shared constants for the UART configuration receiver: sync byte, state
// encodings, default bit timing and the configuration byte-index map.
package uart_config_rx_pkg;

    localparam logic [7:0] SYNC_BYTE            = 8'hA5;
    localparam int         DEFAULT_CLKS_PER_BIT = 87;

    // Byte positions inside the configuration bus
    localparam int BYTE_SPEED_L   = 0;
    localparam int BYTE_SPEED_H   = 1;
    localparam int BYTE_PERCENT   = 2;
    localparam int BYTE_DIRECTION = 3;  // pos1_neg0

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_ADDR = 2'd1,
        P_DATA = 2'd2,
        P_CSUM = 2'd3
    } parser_state_t;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_WAIT  = 3'd4
    } rx_state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [7:0] data);
        return SYNC_BYTE ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, mid-bit sampling timer and LSB-first
// shift register. Flags a low stop bit as byteErr instead of delivering the byte.
module uart_rx_byte
    import uart_config_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk10mhz,
    input  logic       nRst,
    input  logic       uRx,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       byteErr
);

    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uRx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            state     <= R_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byteValid <= 1'b0;
            byteErr   <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            byteErr   <= 1'b0;
            case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) state <= R_START;
                end
                R_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_sync) byteValid <= 1'b1;
                        else         byteErr   <= 1'b1;
                        state <= R_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A low stop bit may be a break; re-arm only once the line is high again.
                R_WAIT: begin
                    if (rx_sync) state <= R_IDLE;
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    assign byteData = shift;

endmodule

// File: rtl/uart_config_rx.sv
// Host-to-board UART config path: parses A5/ADDR/DATA[/CSUM] frames and writes one
// byte of busNow. Define UART_CONFIG_RX_CHECKSUM_EN for the 4-byte checksummed frame.
module uart_config_rx
    import uart_config_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int BUS_WIDTH    = 32,
    parameter int TIMEOUT_CLKS = 8700
) (
    input  logic               clk10mhz,
    input  logic               nRst,
    input  logic               uRx,
    input  logic [BUS_WIDTH:1] busDefault,
    output logic [BUS_WIDTH:1] busNow,
    output logic               cfgUpdate,
    output logic               frameErr
);

    localparam int            NUM_BYTES    = BUS_WIDTH / 8;
    localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CLKS - 1);

    logic          byte_valid;
    logic          byte_err;
    logic [7:0]    byte_data;
    parser_state_t state;
    logic [7:0]    addr_q;
    logic [TW-1:0] timer;
    logic          addr_ok;
    logic          last_byte;
    logic          frame_ok;
    logic [7:0]    wr_data;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk10mhz (clk10mhz),
        .nRst     (nRst),
        .uRx      (uRx),
        .byteValid(byte_valid),
        .byteData (byte_data),
        .byteErr  (byte_err)
    );

    assign addr_ok = ({24'd0, addr_q} < 32'(NUM_BYTES));

`ifdef UART_CONFIG_RX_CHECKSUM_EN
    logic [7:0] data_q;

    assign last_byte = (state == P_CSUM);
    assign wr_data   = data_q;
    assign frame_ok  = addr_ok && (byte_data == frame_csum(addr_q, data_q));
`else
    assign last_byte = (state == P_DATA);
    assign wr_data   = byte_data;
    assign frame_ok  = addr_ok;
`endif

    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            state     <= P_IDLE;
            addr_q    <= '0;
`ifdef UART_CONFIG_RX_CHECKSUM_EN
            data_q    <= '0;
`endif
            timer     <= '0;
            busNow    <= busDefault;
            cfgUpdate <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            cfgUpdate <= 1'b0;
            frameErr  <= 1'b0;
            if (state == P_IDLE) begin
                if (byte_valid && (byte_data == SYNC_BYTE)) begin
                    state <= P_ADDR;
                    timer <= TIMER_RELOAD;
                end
            end else if (byte_err) begin
                frameErr <= 1'b1;
                state    <= P_IDLE;
            end else if (byte_valid) begin
                timer <= TIMER_RELOAD;
                if (last_byte) begin
                    if (frame_ok) begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (addr_q == 8'(k)) busNow[8*k+1 +: 8] <= wr_data;
                        end
                        cfgUpdate <= 1'b1;
                    end else begin
                        frameErr <= 1'b1;
                    end
                    state <= P_IDLE;
                end else begin
                    // Mid-frame bytes are payload; a stray 0xA5 here is not a resync.
                    case (state)
                        P_ADDR: begin
                            addr_q <= byte_data;
                            state  <= P_DATA;
                        end
`ifdef UART_CONFIG_RX_CHECKSUM_EN
                        P_DATA: begin
                            data_q <= byte_data;
                            state  <= P_CSUM;
                        end
`endif
                        default: state <= P_IDLE;
                    endcase
                end
            end else if (timer == '0) begin
                frameErr <= 1'b1;
                state    <= P_IDLE;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_config_rx.sv
// Self-checking bench for uart_config_rx: serial frame driver, pulse scoreboard
// and a bench-side model of the configuration bus.
`timescale 1ns/1ps
module tb_uart_config_rx;

    localparam int          CPB     = 64;
    localparam int          BW      = 32;
    localparam int          TO      = 6400;
    localparam logic [BW:1] BUS_DEF = 32'h0132_6400;
    localparam logic [1:0]  K_UPD   = 2'b01;
    localparam logic [1:0]  K_ERR   = 2'b10;

    logic          clk10mhz = 1'b0;
    logic          nRst     = 1'b0;
    logic          uRx      = 1'b1;
    logic [BW:1]   busDefault;
    logic [BW:1]   busNow;
    logic          cfgUpdate;
    logic          frameErr;

    int            checks    = 0;
    int            failures  = 0;
    int            pulse_cnt = 0;
    int            p0;
    logic [BW+1:0] exp_q[$];
    logic [BW:1]   exp_bus;

    always #50 clk10mhz = ~clk10mhz;

    uart_config_rx #(
        .CLKS_PER_BIT(CPB),
        .BUS_WIDTH   (BW),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk10mhz  (clk10mhz),
        .nRst      (nRst),
        .uRx       (uRx),
        .busDefault(busDefault),
        .busNow    (busNow),
        .cfgUpdate (cfgUpdate),
        .frameErr  (frameErr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation.
    always @(negedge clk10mhz) begin
        if (cfgUpdate || frameErr) begin
            pulse_cnt++;
            if (exp_q.size() == 0)
                check("unexpected_pulse", {30'd0, frameErr, cfgUpdate, busNow}, 64'd0);
            else
                check("pulse", {30'd0, frameErr, cfgUpdate, busNow}, {30'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk10mhz);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uRx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uRx = b[i];
            idle(CPB);
        end
        uRx = stop_bit;
        idle(CPB);
        uRx = 1'b1;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] csum);
        send_byte(8'hA5, 1'b1);
        send_byte(addr, 1'b1);
        send_byte(data, 1'b1);
`ifdef UART_CONFIG_RX_CHECKSUM_EN
        send_byte(csum, 1'b1);
`else
        if (csum === 8'hxx) idle(1);
`endif
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk10mhz);
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
        idle(2 * CPB);
    endtask

    // Good frame: model the write (or the range error) and queue the expected pulse.
    task automatic model_frame(input logic [7:0] addr, input logic [7:0] data);
        if (addr < 8'd4) begin
            exp_bus[8*addr+1 +: 8] = data;
            exp_q.push_back({K_UPD, exp_bus});
        end else begin
            exp_q.push_back({K_ERR, exp_bus});
        end
        send_frame(addr, data, 8'hA5 ^ addr ^ data);
    endtask

    initial begin
        busDefault = BUS_DEF;
        exp_bus    = BUS_DEF;
        idle(5);
        check("reset_bus", busNow, BUS_DEF);
        check("reset_cfg_update", cfgUpdate, 1'b0);
        check("reset_frame_err", frameErr, 1'b0);

        // Quiet line after reset: no pulses
        nRst = 1'b1;
        idle(10000);
        check("idle_pulses", pulse_cnt, 0);
        check("idle_bus", busNow, BUS_DEF);

        // Percent byte write
        exp_bus[24:17] = 8'h50;
        exp_q.push_back({K_UPD, exp_bus});
        send_frame(8'h02, 8'h50, 8'hF7);
        wait_drain("t2_drain", 4 * CPB);
        check("t2_bus", busNow, 32'h0150_6400);

`ifdef UART_CONFIG_RX_CHECKSUM_EN
        exp_q.push_back({K_ERR, exp_bus});
        send_frame(8'h02, 8'h50, 8'h00);
        wait_drain("t3_csum_drain", 4 * CPB);
`endif
        exp_q.push_back({K_ERR, exp_bus});
        send_frame(8'h07, 8'h11, 8'hB3);
        wait_drain("t3_range_drain", 4 * CPB);
        check("t3_bus", busNow, 32'h0150_6400);

        // Timeout after sync and address
        exp_q.push_back({K_ERR, exp_bus});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_drain("t4_timeout_drain", TO + 2000);
        model_frame(8'h00, 8'h3C);
        wait_drain("t4_frame_drain", 4 * CPB);
        check("t4_bus", busNow, 32'h0150_643C);

        // Low stop bit mid-frame, then an idle glitch
        exp_q.push_back({K_ERR, exp_bus});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_drain("t5_stop_drain", 4 * CPB);
        p0 = pulse_cnt;
        uRx = 1'b0;
        idle(20);
        uRx = 1'b1;
        idle(20 * CPB);
        check("t5_glitch_pulses", pulse_cnt - p0, 0);
        check("t5_bus", busNow, 32'h0150_643C);

        // Reset in the middle of the DATA byte
        p0 = pulse_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        uRx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            uRx = i[0];
            idle(CPB);
        end
        nRst = 1'b0;
        idle(3);
        check("t6_reset_bus", busNow, BUS_DEF);
        uRx = 1'b1;
        idle(2);
        nRst = 1'b1;
        exp_bus = BUS_DEF;
        idle(4 * CPB);
        check("t6_reset_pulses", pulse_cnt - p0, 0);
        model_frame(8'h03, 8'h00);
        wait_drain("t6_frame_drain", 4 * CPB);
        check("t6_bus", busNow, 32'h0032_6400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
